// File: rtl/pi_ctrl_pkg.sv
// Shared definitions for the PI run sequencer: state codes and default parameters.
package pi_ctrl_pkg;

  localparam int DATA_W_DEF         = 27;
  localparam int COEFF_W_DEF        = 27;
  localparam int OUT_W_DEF          = 16;
  localparam int CLEAR_CYCLES_DEF   = 2;
  localparam int WARMUP_TIMEOUT_DEF = 16;
  localparam int SAMPLE_TIMEOUT_DEF = 1023;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_WARMUP = 3'd2,
    ST_RUN    = 3'd3,
    ST_FAULT  = 3'd4
  } pi_state_e;

  // One shared counter serves all three timed phases, so size it for the longest.
  function automatic int phase_cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/slew_limiter.sv
// Setpoint ramp: moves the held value toward the target by at most slew_i per step.
module slew_limiter
  import pi_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear_i,
  input  logic                     step_i,
  input  logic signed [DATA_W-1:0] target_i,
  input  logic        [DATA_W-2:0] slew_i,
  output logic signed [DATA_W-1:0] value_o
);

  logic signed [DATA_W:0]   diff;
  logic        [DATA_W:0]   mag;
  logic        [DATA_W:0]   slew_ext;
  logic signed [DATA_W-1:0] moved;
  logic signed [DATA_W-1:0] value_d;
  logic signed [DATA_W-1:0] value_q;

  // A partial step always lands strictly between value and target, so the
  // DATA_W-bit add/subtract for 'moved' cannot wrap.
  always_comb begin
    diff     = {target_i[DATA_W-1], target_i} - {value_q[DATA_W-1], value_q};
    mag      = diff[DATA_W] ? $unsigned(-diff) : $unsigned(diff);
    slew_ext = {2'b00, slew_i};
    moved    = diff[DATA_W] ? (value_q - $signed({1'b0, slew_i}))
                            : (value_q + $signed({1'b0, slew_i}));
    value_d  = value_q;
    if ((slew_i == '0) || (mag <= slew_ext)) begin
      value_d = target_i;
    end else begin
      value_d = moved;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      value_q <= '0;
    end else if (step_i) begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/pi_run_sequencer.sv
// Run sequencer for a PI controller: reset/warmup/run phases, setpoint ramp,
// shadowed coefficient updates, anti-windup flag and sample-loss fault.
module pi_run_sequencer
  import pi_ctrl_pkg::*;
#(
  parameter int DATA_W         = DATA_W_DEF,
  parameter int COEFF_W        = COEFF_W_DEF,
  parameter int OUT_W          = OUT_W_DEF,
  parameter int CLEAR_CYCLES   = CLEAR_CYCLES_DEF,
  parameter int WARMUP_TIMEOUT = WARMUP_TIMEOUT_DEF,
  parameter int SAMPLE_TIMEOUT = SAMPLE_TIMEOUT_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      sample_valid,
  input  logic signed [DATA_W-1:0]  cfg_target,
  input  logic        [DATA_W-2:0]  cfg_slew,
  input  logic signed [COEFF_W-1:0] cfg_kp,
  input  logic signed [COEFF_W-1:0] cfg_ti,
  input  logic                      cfg_load,
  input  logic signed [OUT_W-1:0]   pi_out,
  input  logic                      pi_out_valid,
  output logic                      pi_reset,
  output logic                      pi_enable,
  output logic signed [DATA_W-1:0]  pi_setpoint,
  output logic signed [COEFF_W-1:0] pi_kp,
  output logic signed [COEFF_W-1:0] pi_ti,
  output logic                      pi_limiting,
  output logic        [2:0]         state,
  output logic                      fault
);

  localparam int CNT_W = phase_cnt_width(CLEAR_CYCLES, WARMUP_TIMEOUT, SAMPLE_TIMEOUT);
  localparam logic [CNT_W-1:0] CLR_LAST  = CNT_W'(CLEAR_CYCLES - 1);
  localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(WARMUP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(SAMPLE_TIMEOUT - 1);

  localparam logic signed [OUT_W-1:0] OUT_POS_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OUT_NEG_MAX = {1'b1, {(OUT_W-1){1'b0}}};

  pi_state_e                 state_q;
  logic        [CNT_W-1:0]   cnt_q;
  logic                      pi_reset_q;
  logic                      pi_enable_q;
  logic                      pi_limiting_q;
  logic                      fault_q;
  logic signed [COEFF_W-1:0] kp_q;
  logic signed [COEFF_W-1:0] ti_q;
  logic signed [COEFF_W-1:0] shadow_kp_q;
  logic signed [COEFF_W-1:0] shadow_ti_q;
  logic                      pending_q;

  logic at_rail;
  logic accept_start;
  logic ramp_step;
  logic coeff_apply;

  // stop beats start everywhere; start is only honoured from IDLE or FAULT.
  assign at_rail      = (pi_out == OUT_POS_MAX) || (pi_out == OUT_NEG_MAX);
  assign accept_start = start && !stop && ((state_q == ST_IDLE) || (state_q == ST_FAULT));
  assign ramp_step    = (state_q == ST_RUN) && sample_valid && !stop;
  assign coeff_apply  = ((state_q == ST_RUN) ? sample_valid : pending_q) && (cfg_load || pending_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      pi_reset_q    <= 1'b1;
      pi_enable_q   <= 1'b0;
      pi_limiting_q <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      pi_reset_q <= 1'b0;
      if (stop && (state_q != ST_IDLE)) begin
        state_q       <= ST_IDLE;
        cnt_q         <= '0;
        pi_enable_q   <= 1'b0;
        pi_limiting_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE, ST_FAULT: begin
            if (accept_start) begin
              state_q       <= ST_CLEAR;
              cnt_q         <= '0;
              pi_reset_q    <= 1'b1;
              pi_enable_q   <= 1'b0;
              pi_limiting_q <= 1'b0;
              fault_q       <= 1'b0;
            end
          end
          ST_CLEAR: begin
            if (cnt_q == CLR_LAST) begin
              state_q     <= ST_WARMUP;
              cnt_q       <= '0;
              pi_enable_q <= 1'b1;
            end else begin
              cnt_q      <= cnt_q + 1'b1;
              pi_reset_q <= 1'b1;
            end
          end
          ST_WARMUP: begin
            if (pi_out_valid) begin
              state_q       <= ST_RUN;
              cnt_q         <= '0;
              pi_limiting_q <= at_rail;
            end else if (cnt_q == WARM_LAST) begin
              state_q     <= ST_FAULT;
              cnt_q       <= '0;
              pi_enable_q <= 1'b0;
              fault_q     <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          ST_RUN: begin
            if (pi_out_valid) pi_limiting_q <= at_rail;
            if (sample_valid) begin
              cnt_q <= '0;
            end else if (cnt_q == GAP_LAST) begin
              state_q       <= ST_FAULT;
              cnt_q         <= '0;
              pi_enable_q   <= 1'b0;
              pi_limiting_q <= 1'b0;
              fault_q       <= 1'b1;
            end else if (cnt_q != '1) begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            pi_enable_q   <= 1'b0;
            pi_limiting_q <= 1'b0;
          end
        endcase
      end
    end
  end

  // A load that lands on an apply event bypasses the shadow and goes straight out.
  always_ff @(posedge clk) begin
    if (reset) begin
      kp_q        <= '0;
      ti_q        <= '0;
      shadow_kp_q <= '0;
      shadow_ti_q <= '0;
      pending_q   <= 1'b0;
    end else if (coeff_apply) begin
      kp_q      <= cfg_load ? cfg_kp : shadow_kp_q;
      ti_q      <= cfg_load ? cfg_ti : shadow_ti_q;
      pending_q <= 1'b0;
      if (cfg_load) begin
        shadow_kp_q <= cfg_kp;
        shadow_ti_q <= cfg_ti;
      end
    end else if (cfg_load) begin
      shadow_kp_q <= cfg_kp;
      shadow_ti_q <= cfg_ti;
      pending_q   <= 1'b1;
    end
  end

  slew_limiter #(
    .DATA_W(DATA_W)
  ) u_slew (
    .clk     (clk),
    .reset   (reset),
    .clear_i (accept_start),
    .step_i  (ramp_step),
    .target_i(cfg_target),
    .slew_i  (cfg_slew),
    .value_o (pi_setpoint)
  );

  assign pi_reset    = pi_reset_q;
  assign pi_enable   = pi_enable_q;
  assign pi_kp       = kp_q;
  assign pi_ti       = ti_q;
  assign pi_limiting = pi_limiting_q;
  assign state       = state_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_pi_run_sequencer.sv
// Directed and randomized checks of pi_run_sequencer against an arithmetic setpoint/coefficient model.
module tb_pi_run_sequencer;

  logic               clk;
  logic               reset;
  logic               start;
  logic               stop;
  logic               sample_valid;
  logic signed [26:0] cfg_target;
  logic        [25:0] cfg_slew;
  logic        [26:0] cfg_kp;
  logic        [26:0] cfg_ti;
  logic               cfg_load;
  logic signed [15:0] pi_out;
  logic               pi_out_valid;
  logic               pi_reset;
  logic               pi_enable;
  logic signed [26:0] pi_setpoint;
  logic        [26:0] pi_kp;
  logic        [26:0] pi_ti;
  logic               pi_limiting;
  logic        [2:0]  state;
  logic               fault;

  pi_run_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .sample_valid(sample_valid),
    .cfg_target  (cfg_target),
    .cfg_slew    (cfg_slew),
    .cfg_kp      (cfg_kp),
    .cfg_ti      (cfg_ti),
    .cfg_load    (cfg_load),
    .pi_out      (pi_out),
    .pi_out_valid(pi_out_valid),
    .pi_reset    (pi_reset),
    .pi_enable   (pi_enable),
    .pi_setpoint (pi_setpoint),
    .pi_kp       (pi_kp),
    .pi_ti       (pi_ti),
    .pi_limiting (pi_limiting),
    .state       (state),
    .fault       (fault)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert;
  int n_fail;

  // Reference model state
  int          sp_m;
  int          tgt_m;
  int          slew_m;
  logic [26:0] kp_m;
  logic [26:0] ti_m;
  logic [26:0] sh_kp_m;
  logic [26:0] sh_ti_m;
  bit          pend_m;
  logic [31:0] exp_q[$];

  function automatic int ramp(input int sp, input int tgt, input int slew);
    int d;
    d = tgt - sp;
    if (slew == 0 || (d < 0 ? -d : d) <= slew) return tgt;
    return (d < 0) ? sp - slew : sp + slew;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic set_cfg(input int t, input int s);
    tgt_m      = t;
    slew_m     = s;
    cfg_target = 27'(t);
    cfg_slew   = 26'(s);
  endtask

  task automatic run_sample();
    sp_m = ramp(sp_m, tgt_m, slew_m);
    exp_q.push_back(32'(sp_m));
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    check("setpoint", $signed(pi_setpoint), $signed(exp_q.pop_front()));
  endtask

  task automatic enter_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    sp_m = 0;
    check("clear_state", state, 1);
    check("clear_reset", pi_reset, 1);
    check("clear_fault", fault, 0);
    check("clear_sp", $signed(pi_setpoint), 0);
    tick();
    check("clear_state2", state, 1);
    check("clear_reset2", pi_reset, 1);
    tick();
    check("warm_state", state, 2);
    check("warm_enable", pi_enable, 1);
    check("warm_reset", pi_reset, 0);
    tick();
    tick();
    check("warm_hold", state, 2);
    pi_out       = 16'sh1234;
    pi_out_valid = 1'b1;
    tick();
    pi_out_valid = 1'b0;
    check("run_state", state, 3);
    check("run_lim", pi_limiting, 0);
  endtask

  // One RUN cycle with model update of setpoint and coefficients
  task automatic step_run(input bit sv, input bit load);
    logic [26:0] nkp;
    logic [26:0] nti;
    nkp = 27'($urandom);
    nti = 27'($urandom);
    if (load) begin
      cfg_kp = nkp;
      cfg_ti = nti;
    end
    if (sv) begin
      sp_m = ramp(sp_m, tgt_m, slew_m);
      if (load) begin
        kp_m = nkp; ti_m = nti; pend_m = 0;
      end else if (pend_m) begin
        kp_m = sh_kp_m; ti_m = sh_ti_m; pend_m = 0;
      end
    end else if (load) begin
      sh_kp_m = nkp; sh_ti_m = nti; pend_m = 1;
    end
    exp_q.push_back(32'(sp_m));
    sample_valid = sv;
    cfg_load     = load;
    tick();
    sample_valid = 1'b0;
    cfg_load     = 1'b0;
    check("rnd_sp", $signed(pi_setpoint), $signed(exp_q.pop_front()));
    check("rnd_kp", pi_kp, kp_m);
    check("rnd_ti", pi_ti, ti_m);
    check("rnd_state", state, 3);
  endtask

  initial begin
    n_assert = 0; n_fail = 0;
    reset = 1'b1; start = 1'b0; stop = 1'b0; sample_valid = 1'b0;
    cfg_kp = '0; cfg_ti = '0; cfg_load = 1'b0; pi_out = '0; pi_out_valid = 1'b0;
    set_cfg(0, 0);
    sp_m = 0; kp_m = '0; ti_m = '0; sh_kp_m = '0; sh_ti_m = '0; pend_m = 0;

    tick();
    tick();
    check("rst_state", state, 0);
    check("rst_pireset", pi_reset, 1);
    check("rst_enable", pi_enable, 0);
    check("rst_sp", $signed(pi_setpoint), 0);
    check("rst_kp", pi_kp, 0);
    check("rst_ti", pi_ti, 0);
    check("rst_lim", pi_limiting, 0);
    check("rst_fault", fault, 0);
    reset = 1'b0;
    tick();
    check("idle_pireset", pi_reset, 0);
    check("idle_state", state, 0);

    // Warmup timeout: no pi_out_valid for 16 warmup cycles
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("wt_warm", state, 2);
    for (int i = 0; i < 15; i++) tick();
    check("wt_still_warm", state, 2);
    tick();
    check("wt_fault_state", state, 4);
    check("wt_fault", fault, 1);
    check("wt_enable", pi_enable, 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("wt_stop_state", state, 0);
    check("wt_stop_fault", fault, 1);

    // Ramp up: 1000 at slew 300
    set_cfg(1000, 300);
    enter_run();
    for (int i = 0; i < 5; i++) run_sample();

    // Redirect downward with a larger slew
    set_cfg(-200, 500);
    for (int i = 0; i < 3; i++) run_sample();

    // Coefficient load during a sample gap, then coincident with a sample
    cfg_kp = 27'h100; cfg_ti = 27'h40; cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    check("kp_pending", pi_kp, 0);
    tick(); tick(); tick();
    check("kp_wait", pi_kp, 0);
    check("ti_wait", pi_ti, 0);
    run_sample();
    check("kp_applied", pi_kp, 27'h100);
    check("ti_applied", pi_ti, 27'h40);
    cfg_kp = 27'h200; cfg_ti = 27'h80; cfg_load = 1'b1;
    run_sample();
    cfg_load = 1'b0;
    check("kp_direct", pi_kp, 27'h200);
    check("ti_direct", pi_ti, 27'h80);
    kp_m = 27'h200; ti_m = 27'h80; sh_kp_m = 27'h200; sh_ti_m = 27'h80; pend_m = 0;

    // Anti-windup flag
    pi_out = 16'sh7FFF; pi_out_valid = 1'b1;
    tick();
    check("lim_pos", pi_limiting, 1);
    pi_out = 16'sh8000;
    tick();
    check("lim_neg", pi_limiting, 1);
    pi_out = 16'sh1234;
    tick();
    check("lim_off", pi_limiting, 0);
    pi_out = 16'sh7FFF;
    tick();
    pi_out_valid = 1'b0;
    tick();
    check("lim_hold", pi_limiting, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_state", state, 0);
    check("stop_lim", pi_limiting, 0);
    check("stop_enable", pi_enable, 0);
    check("stop_sp_held", $signed(pi_setpoint), sp_m);

    // Randomized RUN traffic
    enter_run();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0)
        set_cfg(int'($urandom_range(0, 10000)) - 5000,
                ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 700)));
      step_run(bit'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
    end

    // Sample-loss fault after 1023 idle cycles
    step_run(1'b1, 1'b0);
    for (int i = 0; i < 1022; i++) tick();
    check("gap_still_run", state, 3);
    tick();
    check("gap_state", state, 4);
    check("gap_fault", fault, 1);
    check("gap_enable", pi_enable, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("gap_restart_state", state, 1);
    check("gap_restart_fault", fault, 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("clear_stop_state", state, 0);

    // start and stop together in IDLE
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("ss_state", state, 0);
    check("ss_enable", pi_enable, 0);
    check("ss_reset", pi_reset, 0);

    // Reset mid-ramp with a coincident sample
    set_cfg(10000, 100);
    enter_run();
    for (int i = 0; i < 3; i++) run_sample();
    reset = 1'b1; sample_valid = 1'b1; cfg_load = 1'b1;
    tick();
    reset = 1'b0; sample_valid = 1'b0; cfg_load = 1'b0;
    check("mr_state", state, 0);
    check("mr_pireset", pi_reset, 1);
    check("mr_enable", pi_enable, 0);
    check("mr_sp", $signed(pi_setpoint), 0);
    check("mr_kp", pi_kp, 0);
    check("mr_ti", pi_ti, 0);
    check("mr_lim", pi_limiting, 0);
    check("mr_fault", fault, 0);
    tick();
    check("mr_after_state", state, 0);
    check("mr_after_sp", $signed(pi_setpoint), 0);
    check("mr_after_pireset", pi_reset, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
